// File: rtl/zfo_color_indexer_if.sv
// Bundles the palette-write port, the colour request handshake and the
// result handshake of the nearest-colour indexer.
interface zfo_color_indexer_if;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        in_valid;
  logic [11:0] in_rgb;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_index;
  logic [5:0]  out_dist;
  logic        out_ready;

  modport master (
    output pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    input  in_ready, out_valid, out_index, out_dist
  );

  modport slave (
    input  pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    output in_ready, out_valid, out_index, out_dist
  );
endinterface

// File: rtl/zfo_color_indexer.sv
// Inverse palette lookup: given a 12-bit {R,G,B} colour, sequentially scans a
// 16-entry palette register file and returns the index of the entry with the
// smallest Manhattan distance (lowest index wins ties). One entry can be
// excluded as a transparency key.
module zfo_color_indexer #(
  parameter int SKIP_EN    = 1,
  parameter int SKIP_INDEX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  zfo_color_indexer_if.slave    bus
);

  localparam logic [3:0] SKIP_IDX = SKIP_INDEX[3:0];

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] pal [16];
  logic [11:0] rgb;
  logic [3:0]  cnt;
  logic [3:0]  best_idx;
  logic [5:0]  best_dist;
  logic [5:0]  cand_dist;
  logic        cand_skip;
  logic        cand_upd;

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Sum of three 4-bit absolute differences; max 45 fits in 6 bits.
  function automatic logic [5:0] color_dist(input logic [11:0] a, input logic [11:0] b);
    return {2'b00, abs_diff(a[11:8], b[11:8])}
         + {2'b00, abs_diff(a[7:4],  b[7:4])}
         + {2'b00, abs_diff(a[3:0],  b[3:0])};
  endfunction

  assign cand_dist = color_dist(rgb, pal[cnt]);
  assign cand_skip = (SKIP_EN != 0) && (cnt == SKIP_IDX);
  assign cand_upd  = !cand_skip && (cand_dist < best_dist);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: 16 fixed search cycles, then hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)    state_nxt = SEARCH;
      SEARCH:  if (cnt == 4'd15)    state_nxt = DONE;
      DONE:    if (bus.out_ready)   state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Palette register file; writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pal[i] <= 12'h000;
    end else if (bus.pal_we && state == IDLE) begin
      pal[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  // Colour capture, candidate counter and running best match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= 12'h000;
      cnt       <= 4'd0;
      best_idx  <= 4'd0;
      best_dist <= 6'd63;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rgb       <= bus.in_rgb;
            cnt       <= 4'd0;
            best_idx  <= 4'd0;
            best_dist <= 6'd63;
          end
        end
        SEARCH: begin
          cnt <= cnt + 4'd1;
          if (cand_upd) begin
            best_idx  <= cnt;
            best_dist <= cand_dist;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_index = (state == DONE) ? best_idx  : 4'd0;
  assign bus.out_dist  = (state == DONE) ? best_dist : 6'd0;

endmodule

// File: doc/zfo_color_indexer.md
ZFO_COLOR_INDEXER -- requirements
Module: zfo_color_indexer

Interface
REQ-001 Parameters (name, default, meaning):
- SKIP_EN, 1, when 1 the entry at SKIP_INDEX is excluded from the search (transparency key).
- SKIP_INDEX, 1, palette index excluded when SKIP_EN=1; range 0..15.
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 pal_we  input  1  palette write strobe.
REQ-005 pal_waddr  input  4  palette entry to write.
REQ-006 pal_wdata  input  12  entry value {R[11:8], G[7:4], B[3:0]}.
REQ-007 in_valid  input  1  a pixel colour is offered.
REQ-008 in_rgb  input  12  offered colour {R, G, B}, 4 bits each.
REQ-009 in_ready  output  1  the block can accept a colour.
REQ-010 out_valid  output  1  a result is available.
REQ-011 out_index  output  4  index of the nearest palette entry.
REQ-012 out_dist  output  6  distance to that entry.
REQ-013 out_ready  input  1  the consumer accepts the result.

Function
REQ-014 The block SHALL hold a 16 x 12-bit palette register file that decodes in the same format as the colour palette ROM it inverts: entry = {R, G, B}.
REQ-015 The palette SHALL be written at a rising edge only when pal_we=1 and the FSM is in IDLE; writes in SEARCH or DONE SHALL be ignored.
REQ-016 The FSM SHALL have three states: IDLE, SEARCH, and DONE.
REQ-017 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 IDLE -> SEARCH on an edge with in_valid=1 and in_ready=1.
- On that edge the block captures in_rgb.
- On that edge it clears the candidate counter to 0, best_dist to 63, and best_idx to 0.
- If pal_we=1 on the same edge, the palette write SHALL also take effect; it is visible to the search.
REQ-019 In SEARCH the block SHALL evaluate candidate entry c (c = 0..15) on the edge that ends cycle c.
- dist = |R-Rc| + |G-Gc| + |B-Bc|, unsigned, computed 6 bits wide (maximum 45, no overflow).
REQ-020 A candidate SHALL replace the best only if dist < best_dist (strict), so the lowest index wins ties.
REQ-021 A candidate SHALL be skipped (no update) when SKIP_EN=1 and c=SKIP_INDEX.
REQ-022 SEARCH -> DONE on the edge that evaluates c=15; the final compare result is included.
REQ-023 SEARCH SHALL always take exactly 16 cycles; there is no early exit on an exact match.
REQ-024 In DONE:
- out_valid SHALL be 1.
- out_index = best_idx and out_dist = best_dist, held stable until the handshake.
REQ-025 DONE -> IDLE on an edge with out_ready=1; out_valid is 0 in the following cycle.
REQ-026 Latency: out_valid SHALL first be 1 in the cycle after the 16th edge following the acceptance edge.
- Throughput: one result per 18 cycles when out_ready is held at 1.
REQ-027 out_valid SHALL be 0 in IDLE and SEARCH; out_index and out_dist SHALL be 0 whenever out_valid=0.
REQ-028 in_valid asserted outside IDLE SHALL have no effect; in_rgb SHALL be ignored after capture.
REQ-029 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-030 Reset=1 SHALL immediately, without waiting for a clock edge, force the following:
- State = IDLE.
- All palette entries = 12'h000.
- Captured colour, counter, best_idx = 0; best_dist = 63.
- Outputs: in_ready=1, out_valid=0, out_index=0, out_dist=0.
REQ-031 Reset asserted mid-SEARCH or in DONE SHALL abort the operation; no result is emitted after release.
REQ-032 The first edge after Reset deasserts SHALL behave as a normal IDLE edge.

Verification
REQ-033 Exact match:
- Stimulus: load entry 5 = 12'hEBA and all other entries = 12'h000, SKIP_EN=1, then offer 12'hEBA.
- Response: out_index=5, out_dist=0, out_valid rises 16 cycles after acceptance.
REQ-034 Tie and skip:
- Stimulus: entries 1 = 12'hF0F and 3 = 12'hF0F, all others = 12'h000, SKIP_EN=1, SKIP_INDEX=1; offer 12'hF0F.
- Response: out_index=3, out_dist=0.
- With SKIP_EN=0 the same stimulus gives out_index=1.
REQ-035 Nearest-colour arithmetic:
- Stimulus: entries 0 = 12'h211, 2 = 12'h621, others = 12'hFFF; offer 12'h512.
- Response: out_index=2, out_dist=3 (entry 0 distance 4).
REQ-036 Backpressure:
- Stimulus: out_ready=0 for 10 cycles in DONE, while toggling in_valid, in_rgb and pal_we.
- Response: out_valid stays 1, outputs are stable, in_ready=0, the palette is unchanged.
- Then out_ready=1 for one edge -> IDLE, in_ready=1.
REQ-037 Reset mid-search:
- Stimulus: assert Reset during SEARCH cycle 7, asynchronously between edges.
- Response: in_ready=1 and out_valid=0 before the next edge; a readback search of 12'h000 then returns out_index=0, out_dist=0, confirming the palette was cleared.
REQ-038 Back-to-back:
- Stimulus: in_valid and out_ready held at 1 with two different colours.
- Response: two results, with successive acceptances exactly 18 cycles apart.
